// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the decode->execute hazard controller.
package pipeline_hazard_controller_pkg;

    // Register file addressing
    localparam int REG_AW   = 6;
    localparam int NUM_REGS = 1 << REG_AW;

    // Registered controller state, exported on ctrl_state
    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_STALL = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_state_t;

    // Execute jump request encodings; any nonzero value is treated as a jump
    localparam logic [2:0] PCJ_NONE = 3'd0;
    localparam logic [2:0] PCJ_REL  = 3'd1;
    localparam logic [2:0] PCJ_ABS  = 3'd2;

endpackage

// File: rtl/pipeline_hazard_controller_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a writer issues,
// cleared when execute retires the write. Set wins over a same-cycle clear.
module pipeline_hazard_controller_reg_scoreboard
    import pipeline_hazard_controller_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clr1_en,
    input  logic [REG_AW-1:0] clr1_addr,
    input  logic              clr2_en,
    input  logic [REG_AW-1:0] clr2_addr,
    input  logic              set1_en,
    input  logic [REG_AW-1:0] set1_addr,
    input  logic              set2_en,
    input  logic [REG_AW-1:0] set2_addr,
    input  logic [REG_AW-1:0] lk1_addr,
    input  logic [REG_AW-1:0] lk2_addr,
    input  logic [REG_AW-1:0] lk3_addr,
    output logic              lk1_pend,
    output logic              lk2_pend,
    output logic              lk3_pend
);

    logic [NUM_REGS-1:0] pend_reg;
    logic [NUM_REGS-1:0] pend_next;

    // Per-entry next value: sets dominate clears on the same register
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
        localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);
        logic clr_hit;
        logic set_hit;
        assign clr_hit       = (clr1_en && (clr1_addr == IDX)) || (clr2_en && (clr2_addr == IDX));
        assign set_hit       = (set1_en && (set1_addr == IDX)) || (set2_en && (set2_addr == IDX));
        assign pend_next[gi] = set_hit | (pend_reg[gi] & ~clr_hit);
    end

    // Pending vector register, emptied by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // Lookups see only registered state: no retire bypass
    assign lk1_pend = pend_reg[lk1_addr];
    assign lk2_pend = pend_reg[lk2_addr];
    assign lk3_pend = pend_reg[lk3_addr];

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode->execute issue sequencer: RAW/WAW stall against the pending-write
// scoreboard and a timed fetch/decode flush after any execute jump.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_source_1,
    input  logic [REG_AW-1:0] dec_source_2,
    input  logic [REG_AW-1:0] dec_destination,
    input  logic              dec_use_src1,
    input  logic              dec_use_src2,
    input  logic              dec_wr1,
    input  logic              dec_wr2,
    input  logic              exe_wr1_enable,
    input  logic [REG_AW-1:0] exe_wr1,
    input  logic              exe_wr2_enable,
    input  logic [REG_AW-1:0] exe_wr2,
    input  logic [2:0]        pcjumpenable,
    output logic              issue,
    output logic              stall_decode,
    output logic              stall_fetch,
    output logic              flush,
    output logic [1:0]        ctrl_state,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    ctrl_state_t      state_reg, state_next;
    logic [3:0]       fcnt_reg, fcnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             out_en_reg;

    logic active, valid_eff, jump, in_flush, hazard, stall;
    logic pend_src1, pend_src2, pend_dest;

    // Outputs stay quiet while reset is high and for the first cycle after it
    assign active    = out_en_reg & ~reset;
    assign valid_eff = dec_valid & active;
    assign jump      = active & (pcjumpenable != PCJ_NONE);
    assign in_flush  = (state_reg == CTRL_FLUSH);

    pipeline_hazard_controller_reg_scoreboard u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .clr1_en   (exe_wr1_enable),
        .clr1_addr (exe_wr1),
        .clr2_en   (exe_wr2_enable),
        .clr2_addr (exe_wr2),
        .set1_en   (issue & dec_wr1),
        .set1_addr (dec_destination),
        .set2_en   (issue & dec_wr2),
        .set2_addr (dec_source_1),
        .lk1_addr  (dec_source_1),
        .lk2_addr  (dec_source_2),
        .lk3_addr  (dec_destination),
        .lk1_pend  (pend_src1),
        .lk2_pend  (pend_src2),
        .lk3_pend  (pend_dest)
    );

    // A write-back of source_1 (dec_wr2) is a WAW hazard on source_1
    assign hazard = valid_eff & ((dec_use_src1 & pend_src1) | (dec_use_src2 & pend_src2)
                               | (dec_wr1 & pend_dest) | (dec_wr2 & pend_src1));

    assign issue        = valid_eff & ~hazard & ~in_flush & ~jump;
    assign stall        = valid_eff &  hazard & ~in_flush & ~jump;
    assign stall_decode = stall;
    assign stall_fetch  = stall;
    assign flush        = jump | (active & in_flush);
    assign ctrl_state   = state_reg;
    assign stall_cycles = stall_cnt_reg;

    // Next-state logic; a jump from any state (re)arms the flush counter
    always_comb begin
        state_next = state_reg;
        fcnt_next  = fcnt_reg;
        case (state_reg)
            CTRL_RUN: begin
                if (jump) begin
                    state_next = CTRL_FLUSH;
                    fcnt_next  = FLUSH_LOAD;
                end else if (stall) begin
                    state_next = CTRL_STALL;
                end
            end
            CTRL_STALL: begin
                if (jump) begin
                    state_next = CTRL_FLUSH;
                    fcnt_next  = FLUSH_LOAD;
                end else if (!stall) begin
                    state_next = CTRL_RUN;
                end
            end
            CTRL_FLUSH: begin
                if (jump) begin
                    fcnt_next = FLUSH_LOAD;
                end else if (fcnt_reg == 4'd0) begin
                    state_next = CTRL_RUN;
                end else begin
                    fcnt_next = fcnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = CTRL_RUN;
                fcnt_next  = 4'd0;
            end
        endcase
    end

    // State, flush counter and post-reset output enable
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= CTRL_RUN;
            fcnt_reg   <= 4'd0;
            out_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            fcnt_reg   <= fcnt_next;
            out_en_reg <= 1'b1;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomised + directed bench: a cycle-level reference model pushes expected
// outputs into a queue; a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_MAX      = 65535;

    logic       clock = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [5:0] dec_source_1, dec_source_2, dec_destination;
    logic       dec_use_src1, dec_use_src2, dec_wr1, dec_wr2;
    logic       exe_wr1_enable, exe_wr2_enable;
    logic [5:0] exe_wr1, exe_wr2;
    logic [2:0] pcjumpenable;
    logic        issue, stall_decode, stall_fetch, flush;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;

    pipeline_hazard_controller #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .dec_valid(dec_valid),
        .dec_source_1(dec_source_1), .dec_source_2(dec_source_2),
        .dec_destination(dec_destination), .dec_use_src1(dec_use_src1),
        .dec_use_src2(dec_use_src2), .dec_wr1(dec_wr1), .dec_wr2(dec_wr2),
        .exe_wr1_enable(exe_wr1_enable), .exe_wr1(exe_wr1),
        .exe_wr2_enable(exe_wr2_enable), .exe_wr2(exe_wr2),
        .pcjumpenable(pcjumpenable), .issue(issue), .stall_decode(stall_decode),
        .stall_fetch(stall_fetch), .flush(flush), .ctrl_state(ctrl_state),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit issue;
        bit stall;
        bit flush;
        int state;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: what is in flight, how many flush cycles remain
    bit m_pend[64];
    int m_flush_left;
    bit m_stalled;
    int m_stall_cnt;
    bit m_quiet;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs, check against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("issue", 32'(issue), 32'(e.issue));
                chk("stall_decode", 32'(stall_decode), 32'(e.stall));
                chk("stall_fetch", 32'(stall_fetch), 32'(e.stall));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("ctrl_state", 32'(ctrl_state), 32'(e.state));
                chk("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
                if (issue === 1'b1 && e.issue)
                    $display("txn cycle %0d: issued s1=%0d s2=%0d d=%0d", cycle, dec_source_1, dec_source_2, dec_destination);
            end
        end
    end

    // Predict this cycle's outputs, queue them, advance the model and the clock
    task automatic tick();
        exp_t e;
        bit act, v, j, inflush, hz;
        act     = !reset && !m_quiet;
        v       = dec_valid && act;
        j       = act && (pcjumpenable != 0);
        inflush = (m_flush_left > 0);
        hz = v && ((dec_use_src1 && m_pend[dec_source_1]) || (dec_use_src2 && m_pend[dec_source_2])
                || (dec_wr1 && m_pend[dec_destination]) || (dec_wr2 && m_pend[dec_source_1]));
        e.issue = v && !hz && !inflush && !j;
        e.stall = v && hz && !inflush && !j;
        e.flush = j || (act && inflush);
        e.state = inflush ? 2 : (m_stalled ? 1 : 0);
        e.cnt   = m_stall_cnt;
        q.push_back(e);
        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_flush_left = 0;
            m_stalled    = 0;
            m_stall_cnt  = 0;
            m_quiet      = 1;
        end else begin
            m_quiet = 0;
            if (exe_wr1_enable) m_pend[exe_wr1] = 0;
            if (exe_wr2_enable) m_pend[exe_wr2] = 0;
            if (e.issue && dec_wr1) m_pend[dec_destination] = 1;
            if (e.issue && dec_wr2) m_pend[dec_source_1] = 1;
            m_flush_left = j ? FLUSH_CYCLES : (inflush ? m_flush_left - 1 : 0);
            m_stalled    = e.stall;
            if (e.stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        end
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic instr(input bit v, input int s1, input int s2, input int d,
                         input bit u1, input bit u2, input bit w1, input bit w2);
        dec_valid = v; dec_source_1 = 6'(s1); dec_source_2 = 6'(s2); dec_destination = 6'(d);
        dec_use_src1 = u1; dec_use_src2 = u2; dec_wr1 = w1; dec_wr2 = w2;
    endtask

    task automatic retire(input bit e1, input int r1, input bit e2, input int r2);
        exe_wr1_enable = e1; exe_wr1 = 6'(r1); exe_wr2_enable = e2; exe_wr2 = 6'(r2);
    endtask

    initial begin
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        retire(0, 0, 0, 0);
        pcjumpenable = 3'd0;
        reset = 1'b1;
        foreach (m_pend[i]) m_pend[i] = 0;
        m_flush_left = 0; m_stalled = 0; m_stall_cnt = 0; m_quiet = 1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Quiet cycle after reset: even a valid instruction and jump are ignored
        instr(1, 1, 2, 3, 1, 1, 1, 0); pcjumpenable = 3'd1; tick();
        pcjumpenable = 3'd0; instr(0, 0, 0, 0, 0, 0, 0, 0); tick();

        // RAW: write r5, then read r5 until it retires (no bypass)
        instr(1, 1, 2, 5, 1, 1, 1, 0); tick();
        instr(1, 5, 0, 6, 1, 0, 0, 0); repeat (3) tick();
        retire(1, 5, 0, 0); tick();
        retire(0, 0, 0, 0); tick();
        instr(0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Independent stream, then retire both destinations
        instr(1, 1, 2, 3, 1, 1, 1, 0); tick();
        instr(1, 4, 6, 7, 1, 1, 1, 0); tick();
        instr(0, 0, 0, 0, 0, 0, 0, 0); retire(1, 3, 1, 7); tick();
        retire(0, 0, 0, 0); tick();

        // Absolute jump while decode holds an instruction
        instr(1, 1, 2, 4, 1, 1, 1, 0); pcjumpenable = 3'd2; tick();
        pcjumpenable = 3'd0; instr(1, 1, 2, 11, 1, 1, 0, 0); repeat (4) tick();

        // Post-increment load: both write ports set, both retire together
        instr(1, 9, 0, 8, 1, 0, 1, 1); tick();
        instr(1, 8, 0, 12, 1, 0, 0, 0); tick();
        retire(1, 8, 1, 9); tick();
        retire(0, 0, 0, 0); instr(1, 9, 8, 13, 1, 1, 0, 0); tick();

        // Same-cycle retire and issue of r5: set wins, following read stalls
        instr(1, 1, 2, 5, 1, 1, 1, 0); retire(1, 5, 0, 0); tick();
        retire(0, 0, 0, 0); instr(1, 5, 0, 14, 1, 0, 0, 0); repeat (2) tick();
        retire(1, 5, 0, 0); tick();
        retire(0, 0, 0, 0); tick();

        // Reset in the middle of a flush with r10 pending
        instr(1, 1, 2, 10, 1, 1, 1, 0); tick();
        instr(1, 10, 0, 15, 1, 0, 0, 0); pcjumpenable = 3'd7; tick();
        pcjumpenable = 3'd0; tick();
        reset = 1'b1; tick();
        reset = 1'b0; repeat (3) tick();
        instr(0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Randomised traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            instr($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7), $urandom_range(7),
                  $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(3) == 0);
            retire($urandom_range(9) < 3, $urandom_range(7), $urandom_range(9) < 3, $urandom_range(7));
            pcjumpenable = ($urandom_range(99) < 4) ? 3'($urandom_range(1, 7)) : 3'd0;
            reset = ($urandom_range(99) == 0);
            tick();
        end
        reset = 1'b0; pcjumpenable = 3'd0;
        retire(0, 0, 0, 0); instr(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1; tick();
        reset = 1'b0; tick();

        // Stall counter saturation: hold a dependent read past 2^16 cycles
        instr(1, 1, 2, 20, 1, 1, 1, 0); tick();
        instr(1, 20, 0, 21, 1, 0, 0, 0);
        repeat (65536 + 3) tick();
        retire(1, 20, 0, 0); tick();
        retire(0, 0, 0, 0); tick();
        instr(0, 0, 0, 0, 0, 0, 0, 0); tick();

        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
